// File: rtl/mouse_tracker_if.sv
// Byte stream from the PS/2 receiver into the tracker, plus the cursor state
// and status pulses the tracker publishes to the grid controller.
interface mouse_tracker_if;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [9:0] x_mouse;
    logic [9:0] y_mouse;
    logic       mouse_click;
    logic       pkt_valid;
    logic       sync_err;

    modport master (
        output rx_valid, rx_byte,
        input  x_mouse, y_mouse, mouse_click, pkt_valid, sync_err
    );

    modport slave (
        input  rx_valid, rx_byte,
        output x_mouse, y_mouse, mouse_click, pkt_valid, sync_err
    );
endinterface

// File: rtl/mouse_tracker.sv
// Assembles 3-byte PS/2 mouse packets and integrates the deltas into a clamped
// cursor position; drops mis-framed bytes and abandons stalled packets.
module mouse_tracker #(
    parameter int X_MAX   = 159,
    parameter int Y_MAX   = 127,
    parameter int X_INIT  = 80,
    parameter int Y_INIT  = 64,
    parameter int TIMEOUT = 50000
) (
    input  logic            clk,
    input  logic            reset,
    mouse_tracker_if.slave  bus
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]    TO_LAST   = CW'(TIMEOUT - 1);
    localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
    localparam logic signed [11:0] Y_MAX_S = 12'(Y_MAX);

    typedef enum logic [1:0] {W0, W1, W2} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    // Only the header bits that matter are kept: overflow, sign and left button.
    logic          ovf_x, ovf_y, sgn_x, sgn_y, btn;
    logic          ovf_x_n, ovf_y_n, sgn_x_n, sgn_y_n, btn_n;
    logic [7:0]    xb, xb_n;
    logic [9:0]    x_q, y_q, x_n, y_n;
    logic          click_q, click_n;
    logic          pkt_q, pkt_n;
    logic          err_q, err_n;

    logic signed [8:0]  dx, dy;
    logic signed [11:0] x_sum, y_sum;
    logic [9:0]         x_clamp, y_clamp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= W0;
            cnt     <= '0;
            ovf_x   <= 1'b0;
            ovf_y   <= 1'b0;
            sgn_x   <= 1'b0;
            sgn_y   <= 1'b0;
            btn     <= 1'b0;
            xb      <= '0;
            x_q     <= 10'(X_INIT);
            y_q     <= 10'(Y_INIT);
            click_q <= 1'b0;
            pkt_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ovf_x   <= ovf_x_n;
            ovf_y   <= ovf_y_n;
            sgn_x   <= sgn_x_n;
            sgn_y   <= sgn_y_n;
            btn     <= btn_n;
            xb      <= xb_n;
            x_q     <= x_n;
            y_q     <= y_n;
            click_q <= click_n;
            pkt_q   <= pkt_n;
            err_q   <= err_n;
        end
    end

    // Sums are 12-bit signed so the clamp sees true out-of-range values.
    always_comb begin
        dx    = ovf_x ? '0 : {sgn_x, xb};
        dy    = ovf_y ? '0 : {sgn_y, bus.rx_byte};
        x_sum = $signed({2'b00, x_q}) + {{3{dx[8]}}, dx};
        y_sum = $signed({2'b00, y_q}) - {{3{dy[8]}}, dy};

        if (x_sum < 0)            x_clamp = '0;
        else if (x_sum > X_MAX_S) x_clamp = X_MAX_S[9:0];
        else                      x_clamp = x_sum[9:0];

        if (y_sum < 0)            y_clamp = '0;
        else if (y_sum > Y_MAX_S) y_clamp = Y_MAX_S[9:0];
        else                      y_clamp = y_sum[9:0];
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ovf_x_n = ovf_x;
        ovf_y_n = ovf_y;
        sgn_x_n = sgn_x;
        sgn_y_n = sgn_y;
        btn_n   = btn;
        xb_n    = xb;
        x_n     = x_q;
        y_n     = y_q;
        click_n = click_q;
        pkt_n   = 1'b0;
        err_n   = 1'b0;

        unique case (state)
            W0: begin
                cnt_n = '0;
                if (bus.rx_valid) begin
                    if (bus.rx_byte[3]) begin
                        ovf_y_n = bus.rx_byte[7];
                        ovf_x_n = bus.rx_byte[6];
                        sgn_y_n = bus.rx_byte[5];
                        sgn_x_n = bus.rx_byte[4];
                        btn_n   = bus.rx_byte[0];
                        state_n = W1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            W1, W2: begin
                // A byte arriving on the timeout cycle takes priority.
                if (bus.rx_valid) begin
                    cnt_n = '0;
                    if (state == W1) begin
                        xb_n    = bus.rx_byte;
                        state_n = W2;
                    end else begin
                        x_n     = x_clamp;
                        y_n     = y_clamp;
                        click_n = btn;
                        pkt_n   = 1'b1;
                        state_n = W0;
                    end
                end else if (cnt == TO_LAST) begin
                    cnt_n   = '0;
                    err_n   = 1'b1;
                    state_n = W0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = W0;
        endcase
    end

    assign bus.x_mouse     = x_q;
    assign bus.y_mouse     = y_q;
    assign bus.mouse_click = click_q;
    assign bus.pkt_valid   = pkt_q;
    assign bus.sync_err    = err_q;
endmodule

// File: tb/tb_mouse_tracker.sv
// Directed bench for mouse_tracker: a table of bytes with hand-computed cursor
// results, plus sequences for timeout, timeout/byte collision and mid-packet reset.
module tb_mouse_tracker;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mouse_tracker_if bus ();

    mouse_tracker #(
        .X_MAX  (159),
        .Y_MAX  (127),
        .X_INIT (80),
        .Y_INIT (64),
        .TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         x;
        int         y;
        int         c;
        int         p;
        int         s;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] b, input int x, input int y,
                       input int c, input int p, input int s);
        vec_t v;
        v.b = b; v.x = x; v.y = y; v.c = c; v.p = p; v.s = s;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int x, input int y,
                             input int c, input int p, input int s);
        check({tag, ".x"},    int'(bus.x_mouse),   x);
        check({tag, ".y"},    int'(bus.y_mouse),   y);
        check({tag, ".clk"},  int'(bus.mouse_click), c);
        check({tag, ".pkt"},  int'(bus.pkt_valid), p);
        check({tag, ".serr"}, int'(bus.sync_err),  s);
    endtask

    // Entered and left at a negedge; the byte is captured by the posedge between.
    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        @(posedge clk);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_all("in_reset", 80, 64, 0, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  seen;
        bit  early;

        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;

        // basic packet, bad framing, overflow, sign handling, clamps at both edges
        add(8'h09, 80, 64, 0, 0, 0); add(8'h05, 80, 64, 0, 0, 0); add(8'h03, 85, 61, 1, 1, 0);
        add(8'h00, 85, 61, 1, 0, 1);
        add(8'h08, 85, 61, 1, 0, 0); add(8'h01, 85, 61, 1, 0, 0); add(8'h01, 86, 60, 0, 1, 0);
        add(8'hF7, 86, 60, 0, 0, 1);
        add(8'h49, 86, 60, 0, 0, 0); add(8'h7F, 86, 60, 0, 0, 0); add(8'h02, 86, 58, 1, 1, 0);
        add(8'h28, 86, 58, 1, 0, 0); add(8'h00, 86, 58, 1, 0, 0); add(8'hFE, 86, 60, 0, 1, 0);
        add(8'h08, 86, 60, 0, 0, 0); add(8'h00, 86, 60, 0, 0, 0); add(8'h7F, 86, 0, 0, 1, 0);
        add(8'h28, 86, 0, 0, 0, 0);  add(8'h00, 86, 0, 0, 0, 0);  add(8'h00, 86, 127, 0, 1, 0);
        add(8'h88, 86, 127, 0, 0, 0); add(8'h03, 86, 127, 0, 0, 0); add(8'h10, 89, 127, 0, 1, 0);
        add(8'h18, 89, 127, 0, 0, 0); add(8'h00, 89, 127, 0, 0, 0); add(8'h00, 0, 127, 0, 1, 0);
        add(8'h08, 0, 127, 0, 0, 0);  add(8'h02, 0, 127, 0, 0, 0);  add(8'h00, 2, 127, 0, 1, 0);
        add(8'h18, 2, 127, 0, 0, 0);  add(8'hF6, 2, 127, 0, 0, 0);  add(8'h00, 0, 127, 0, 1, 0);
        add(8'h08, 0, 127, 0, 0, 0);  add(8'h7F, 0, 127, 0, 0, 0);  add(8'h00, 127, 127, 0, 1, 0);
        add(8'h08, 127, 127, 0, 0, 0); add(8'h1C, 127, 127, 0, 0, 0); add(8'h00, 155, 127, 0, 1, 0);
        add(8'h08, 155, 127, 0, 0, 0); add(8'h14, 155, 127, 0, 0, 0); add(8'h00, 159, 127, 0, 1, 0);

        @(negedge clk);
        @(negedge clk);
        check_all("reset", 80, 64, 0, 0, 0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            send(vecs[i].b);
            check_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].y,
                      vecs[i].c, vecs[i].p, vecs[i].s);
        end
        @(negedge clk);
        check("pkt_pulse_width", int'(bus.pkt_valid), 0);

        // Timeout abandons the partial packet after exactly TO idle cycles.
        do_reset();
        send(8'h08);
        send(8'h05);
        seen = 1'b0;
        k = 0;
        for (int n = 1; n <= TO + 4; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.sync_err) begin
                seen = 1'b1;
                k = n;
                break;
            end
        end
        check("timeout_seen", int'(seen), 1);
        check("timeout_cycles", k, TO);
        check_all("timeout_hold", 80, 64, 0, 0, 1);
        @(negedge clk);
        check("timeout_pulse_width", int'(bus.sync_err), 0);
        send(8'h08); send(8'h01); send(8'h00);
        check_all("after_timeout", 81, 64, 0, 1, 0);

        // Bytes landing on the timeout cycle are accepted.
        send(8'h08);
        early = 1'b0;
        repeat (TO - 1) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.sync_err) early = 1'b1;
        end
        send(8'h01);
        check("collide_x_serr", int'(bus.sync_err | early), 0);
        repeat (TO - 1) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.sync_err) early = 1'b1;
        end
        send(8'h00);
        check("collide_no_timeout", int'(early), 0);
        check_all("collide_pkt", 82, 64, 0, 1, 0);

        // Reset mid-packet discards the stored header and X byte.
        do_reset();
        send(8'h08);
        send(8'h10);
        do_reset();
        @(negedge clk);
        send(8'h08); send(8'h02); send(8'h00);
        check_all("reset_midpkt", 82, 64, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mouse_tracker.md
MOUSE_TRACKER -- requirements
Module: mouse_tracker

Interface
REQ-001 Parameter X_MAX, default 159, meaning: largest cursor x pixel (40 cells x 4 px, minus 1).
REQ-002 Parameter Y_MAX, default 127, meaning: largest cursor y pixel (32 rows x 4 px, minus 1).
REQ-003 Parameter X_INIT, default 80, meaning: cursor x after reset.
REQ-004 Parameter Y_INIT, default 64, meaning: cursor y after reset.
REQ-005 Parameter TIMEOUT, default 50000, meaning: maximum idle cycles between bytes of one packet.
REQ-006 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 Port reset  input  1  asynchronous, active-high reset.
REQ-008 Port rx_valid  input  1  one-cycle strobe: rx_byte holds a received PS/2 mouse byte.
REQ-009 Port rx_byte  input  8  received byte, sampled only when rx_valid=1.
REQ-010 Port x_mouse  output  10  cursor x pixel, 0..X_MAX, feeds the grid controller.
REQ-011 Port y_mouse  output  10  cursor y pixel, 0..Y_MAX, feeds the grid controller.
REQ-012 Port mouse_click  output  1  left-button level from the last accepted packet.
REQ-013 Port pkt_valid  output  1  one-cycle pulse after every accepted packet.
REQ-014 Port sync_err  output  1  one-cycle pulse when a byte is dropped for bad framing or a packet is abandoned on timeout.

Function
REQ-015 The block SHALL be a 3-state FSM: W0 (await header), W1 (await X delta), W2 (await Y delta).
REQ-016 In W0, on rx_valid with rx_byte[3]=1: store header, go to W1.
REQ-017 In W0, on rx_valid with rx_byte[3]=0: discard byte, stay in W0, pulse sync_err on the next cycle.
REQ-018 In W1, on rx_valid: store byte as X delta low bits, go to W2.
REQ-019 In W2, on rx_valid: go to W0; on that same edge update x_mouse, y_mouse and mouse_click; assert pkt_valid for exactly the following cycle.
REQ-020 X delta = signed 9-bit {header[4], xbyte}; Y delta = signed 9-bit {header[5], ybyte}.
REQ-021 New x = x_mouse + X delta; new y = y_mouse - Y delta (PS/2 +Y is up, screen +y is down).
REQ-022 Both sums SHALL be computed in at least 11-bit signed arithmetic, with no wrap-around.
REQ-023 Clamping: a result < 0 SHALL become 0; a result > X_MAX (or Y_MAX) SHALL become X_MAX (or Y_MAX).
REQ-024 header[6]=1 (X overflow) SHALL force X delta to 0; header[7]=1 (Y overflow) SHALL force Y delta to 0; the button update still applies.
REQ-025 mouse_click SHALL take header[0] of the accepted packet.
REQ-026 An idle counter SHALL clear on every rx_valid and increment each cycle in W1/W2.
REQ-027 When the idle counter reaches TIMEOUT-1 in W1/W2 with no rx_valid: go to W0, discard the partial packet, leave outputs unchanged, pulse sync_err.
REQ-028 Simultaneous rx_valid and timeout: the byte wins, and the timeout is ignored.
REQ-029 rx_valid held high for several cycles SHALL be treated as one byte per asserted cycle; no internal edge detection.
REQ-030 Outputs SHALL be registered; no combinational path from rx_byte to any output.

Reset
REQ-031 While reset=1: state=W0, x_mouse=X_INIT, y_mouse=Y_INIT, mouse_click=0, pkt_valid=0, sync_err=0, idle counter=0.
REQ-032 Reset asserted mid-packet SHALL discard stored bytes; the first byte after release is treated as a header.

Verification
REQ-033 Reset, then bytes 0x09,0x05,0x03 -> x_mouse=85, y_mouse=61, mouse_click=1, one pkt_valid pulse.
REQ-034 From x=2: bytes 0x18,0xF6,0x00 (dx=-10) -> x_mouse=0. From x=155: header 0x08, dx=+20 -> x_mouse=159.
REQ-035 Bytes 0x00 then 0x08,0x01,0x01 -> one sync_err pulse on the first byte, then accepted packet: x+1, y-1.
REQ-036 Bytes 0x08,0x05, then no byte for TIMEOUT cycles -> sync_err pulse, state W0; next 0x08,0x01,0x00 -> x+1, with no 0x05 contribution.
REQ-037 Bytes 0x49,0x7F,0x02 -> x unchanged (overflow), y-2, mouse_click=1.
REQ-038 Reset asserted after 0x08,0x10 and released, then 0x08,0x02,0x00 -> x_mouse=82, y_mouse=64.
